rvv_backend_pmtrdt_rs: RTL

- In-order reservation station (multi-port circular FIFO) feeding the PMTRDT execution stage.
- Accepts up to NUM_DP uops per cycle from dispatch.
- Presents the oldest NUM_PMTRDT uops to the execution units, and pops up to NUM_PMTRDT per cycle.
- Exposes the whole queue, oldest-first, so unit 0 (compress) can look ahead at younger uops.

---
 rtl/rvv_backend_pmtrdt_rs_pkg.sv | 31 +++
 rtl/rvv_backend_rs_ptr.sv | 56 +++++
 rtl/rvv_backend_pmtrdt_rs.sv | 113 +++++++++++
 3 files changed

// File: rtl/rvv_backend_pmtrdt_rs_pkg.sv
// Shared types and defaults for the PMTRDT reservation station.
// Fallback macro values apply only when no shared backend define header has set them.
`ifndef NUM_PMTRDT
`define NUM_PMTRDT 2
`endif
`ifndef PMTRDT_RS_DEPTH
`define PMTRDT_RS_DEPTH 8
`endif

package rvv_backend_pmtrdt_rs_pkg;

  localparam int RS_DEPTH_DFLT = `PMTRDT_RS_DEPTH;
  localparam int NUM_PU_DFLT   = `NUM_PMTRDT;
  localparam int NUM_DP_DFLT   = 2;

  typedef struct packed {
    logic [4:0]  rob_entry;
    logic [5:0]  uop_funct6;
    logic [2:0]  vsew;
    logic [31:0] vs1_data;
  } PMT_RDT_RS_t;

  // Ones count of a thermometer-coded request vector.
  function automatic int unsigned popcnt(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rvv_backend_rs_ptr.sv
// Head/tail/count register for an in-order reservation station with
// thermometer-coded multi-port push and pop.
module rvv_backend_rs_ptr
  import rvv_backend_pmtrdt_rs_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 2,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [NUM_IN-1:0]  push,
  input  logic [NUM_OUT-1:0] pop,
  output logic [PTR_W-1:0]   head,
  output logic [PTR_W-1:0]   tail,
  output logic [CNT_W-1:0]   count
);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_push, n_pop;

  always_comb begin
    n_push  = CNT_W'(popcnt(32'(push)));
    n_pop   = CNT_W'(popcnt(32'(pop)));
    head_d  = head_q + PTR_W'(n_pop);
    tail_d  = tail_q + PTR_W'(n_push);
    count_d = count_q + n_push - n_pop;
    // Flush wins over any same-cycle push or pop.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;

endmodule

// File: rtl/rvv_backend_pmtrdt_rs.sv
// In-order PMTRDT reservation station: multi-port circular FIFO, oldest-first views.
// Optional macro PMTRDT_RS_FLUSH_EN adds the trap_flush_rvv input.
`ifndef NUM_PMTRDT
`define NUM_PMTRDT 2
`endif
`ifndef PMTRDT_RS_DEPTH
`define PMTRDT_RS_DEPTH 8
`endif

module rvv_backend_pmtrdt_rs
  import rvv_backend_pmtrdt_rs_pkg::*;
#(
  parameter int DEPTH  = `PMTRDT_RS_DEPTH,  // power of 2, >= NUM_PU
  parameter int NUM_DP = 2,
  parameter int NUM_PU = `NUM_PMTRDT
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef PMTRDT_RS_FLUSH_EN
  input  logic                         trap_flush_rvv,
`endif
  input  logic [NUM_DP-1:0]            push_valid_dp2rs,
  input  PMT_RDT_RS_t [NUM_DP-1:0]     push_data_dp2rs,
  output logic [NUM_DP-1:0]            push_ready_rs2dp,
  input  logic [NUM_PU-1:0]            pop_ex2rs,
  output PMT_RDT_RS_t [NUM_PU-1:0]     pmtrdt_uop_rs2ex,
  output logic                         fifo_empty_rs2ex,
  output logic [NUM_PU-1:1]            fifo_almost_empty_rs2ex,
  output PMT_RDT_RS_t [DEPTH-1:0]      all_uop_data,
  output logic                         fifo_full_rs2dp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, free_cnt;
  logic [NUM_DP-1:0] push_acc;
  logic              flush;
  PMT_RDT_RS_t       mem_q [DEPTH];
  PMT_RDT_RS_t       mem_d [DEPTH];

`ifdef PMTRDT_RS_FLUSH_EN
  assign flush = trap_flush_rvv;
`else
  assign flush = 1'b0;
`endif

  // Ready looks only at the registered count so EX pops never reach dispatch combinationally.
  always_comb begin
    free_cnt = CNT_W'(DEPTH) - count;
    for (int j = 0; j < NUM_DP; j++)
      push_ready_rs2dp[j] = (free_cnt >= CNT_W'(j + 1));
  end

  assign push_acc = push_valid_dp2rs & push_ready_rs2dp;

  rvv_backend_rs_ptr #(
    .DEPTH   (DEPTH),
    .NUM_IN  (NUM_DP),
    .NUM_OUT (NUM_PU)
  ) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push_acc),
    .pop   (pop_ex2rs),
    .head  (head),
    .tail  (tail),
    .count (count)
  );

  always_comb begin
    for (int k = 0; k < DEPTH; k++) mem_d[k] = mem_q[k];
    for (int j = 0; j < NUM_DP; j++)
      if (push_acc[j]) mem_d[tail + PTR_W'(j)] = push_data_dp2rs[j];
  end

  // Payload storage carries no reset; validity lives entirely in count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) mem_q[k] <= mem_d[k];
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_rd
    assign all_uop_data[k] = mem_q[head + PTR_W'(k)];
  end

  for (genvar i = 0; i < NUM_PU; i++) begin : g_pu
    assign pmtrdt_uop_rs2ex[i] = all_uop_data[i];
  end

  always_comb begin
    for (int i = 1; i < NUM_PU; i++)
      fifo_almost_empty_rs2ex[i] = (count <= CNT_W'(i));
  end

  assign fifo_empty_rs2ex = (count == '0);
  assign fifo_full_rs2dp  = (count == CNT_W'(DEPTH));

  a_push_thermo: assert property (@(posedge clk) disable iff (!rst_n)
    ((push_valid_dp2rs + NUM_DP'(1)) & push_valid_dp2rs) == '0);
  a_pop_thermo: assert property (@(posedge clk) disable iff (!rst_n)
    ((pop_ex2rs + NUM_PU'(1)) & pop_ex2rs) == '0);
  a_push_ready: assert property (@(posedge clk) disable iff (!rst_n)
    (push_valid_dp2rs & ~push_ready_rs2dp) == '0);
  a_pop0_valid: assert property (@(posedge clk) disable iff (!rst_n)
    pop_ex2rs[0] |-> !fifo_empty_rs2ex);
  for (genvar i = 1; i < NUM_PU; i++) begin : g_pop_chk
    a_pop_valid: assert property (@(posedge clk) disable iff (!rst_n)
      pop_ex2rs[i] |-> !fifo_almost_empty_rs2ex[i]);
  end

endmodule
